// File: rtl/nonce_result_scanner.sv
// Reads back the per-nonce H0 words written by the hasher and reports the
// minimum-H0 nonce plus how many words fell below the difficulty target.
module nonce_result_scanner #(
  parameter int NUM_NONCE = 16,
  parameter int IDX_W     = $clog2(NUM_NONCE),
  parameter int CNT_W     = $clog2(NUM_NONCE + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      result_addr,
  input  logic [31:0]      target,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] best_nonce,
  output logic [31:0]      best_hash,
  output logic [CNT_W-1:0] hit_count,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  input  logic [31:0]      mem_read_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCE - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t           state, state_nxt;
  logic [15:0]      base;
  logic [31:0]      tgt;
  logic [IDX_W-1:0] offset;
  logic [IDX_W-1:0] cap;
  logic             rd_vld;
  logic             accept;
  logic             capture;
  logic             last_cap;
  logic [CNT_W-1:0] hit_nxt;

  assign mem_clk  = clk;
  assign mem_we   = 1'b0;
  assign mem_addr = base + 16'(offset);

  // rd_vld marks that the RAM has had one full cycle to return the word at cap
  assign accept   = (state == S_IDLE) && start;
  assign capture  = (state == S_READ) && rd_vld;
  assign last_cap = capture && (cap == LAST_IDX);
  assign hit_nxt  = hit_count + CNT_W'(mem_read_data < tgt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_READ;
      S_READ:  if (last_cap) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base       <= '0;
      tgt        <= '0;
      offset     <= '0;
      cap        <= '0;
      rd_vld     <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      best_nonce <= '0;
      best_hash  <= 32'hFFFF_FFFF;
      hit_count  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        base       <= result_addr;
        tgt        <= target;
        offset     <= '0;
        cap        <= '0;
        rd_vld     <= 1'b0;
        found      <= 1'b0;
        best_nonce <= '0;
        best_hash  <= 32'hFFFF_FFFF;
        hit_count  <= '0;
      end else if (state == S_READ) begin
        rd_vld <= 1'b1;
        if (offset != LAST_IDX) offset <= offset + IDX_W'(1);
        if (capture) begin
          // strict compare keeps the lowest index on equal H0 values
          if (mem_read_data < best_hash) begin
            best_hash  <= mem_read_data;
            best_nonce <= cap;
          end
          hit_count <= hit_nxt;
          found     <= (hit_nxt != '0);
          cap       <= cap + IDX_W'(1);
          if (last_cap) done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Randomized + directed bench: a RAM model feeds the scanner, a scoreboard
// queue holds expected results, and a done-triggered monitor checks them.
module tb_nonce_result_scanner;
  localparam int NUM_NONCE = 16;
  localparam int IDX_W     = $clog2(NUM_NONCE);
  localparam int CNT_W     = $clog2(NUM_NONCE + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [15:0]      result_addr;
  logic [31:0]      target;
  logic             done, found;
  logic [IDX_W-1:0] best_nonce;
  logic [31:0]      best_hash;
  logic [CNT_W-1:0] hit_count;
  logic             mem_clk, mem_we;
  logic [15:0]      mem_addr;
  logic [31:0]      mem_read_data;

  logic [31:0] ram [0:65535];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit we_seen = 1'b0;

  typedef struct {
    logic [IDX_W-1:0] nonce;
    logic [31:0]      hash;
    logic [CNT_W-1:0] hits;
    logic             fnd;
    int               e0;
  } exp_t;
  exp_t sb_q[$];

  nonce_result_scanner #(.NUM_NONCE(NUM_NONCE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .result_addr(result_addr),
    .target(target), .done(done), .found(found), .best_nonce(best_nonce),
    .best_hash(best_hash), .hit_count(hit_count), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_read_data <= ram[mem_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: find the minimum value, then the first index holding it.
  function automatic exp_t model(input logic [15:0] b, input logic [31:0] t);
    exp_t e;
    logic [31:0] mn;
    int hits;
    mn = 32'hFFFF_FFFF;
    hits = 0;
    for (int j = 0; j < NUM_NONCE; j++) begin
      if (ram[16'(b + j)] < mn) mn = ram[16'(b + j)];
      if (ram[16'(b + j)] < t) hits++;
    end
    e.nonce = '0;
    for (int j = NUM_NONCE - 1; j >= 0; j--)
      if (ram[16'(b + j)] == mn) e.nonce = IDX_W'(j);
    e.hash = mn;
    e.hits = CNT_W'(hits);
    e.fnd  = (hits != 0);
    e.e0   = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (mem_we) we_seen = 1'b1;
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("latency",    cyc - e.e0, NUM_NONCE + 1);
        chk("best_nonce", best_nonce, e.nonce);
        chk("best_hash",  best_hash,  e.hash);
        chk("hit_count",  hit_count,  e.hits);
        chk("found",      found,      e.fnd);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that raises done.
  task automatic run_scan(input logic [15:0] b, input logic [31:0] t,
                          input bit hold, input bit chk_addr);
    exp_t e;
    int n;
    start = 1'b1; result_addr = b; target = t;
    e = model(b, t);
    @(posedge clk); #1;
    e.e0 = cyc;
    sb_q.push_back(e);
    if (!hold) start = 1'b0;
    for (int k = 0; k < NUM_NONCE; k++) begin
      if (chk_addr) chk("mem_addr", mem_addr, 16'(b + k));
      if (hold) begin result_addr = 16'($urandom); target = $urandom; end
      if (hold && k == NUM_NONCE - 1) start = 1'b0;
      @(posedge clk); #1;
    end
    n = 0;
    while (!done && n < 8) begin @(posedge clk); #1; n++; end
    if (!done) begin
      chk("done_timeout", 0, 1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_done",       done,       0);
    chk("rst_found",      found,      0);
    chk("rst_best_nonce", best_nonce, 0);
    chk("rst_best_hash",  best_hash,  32'hFFFF_FFFF);
    chk("rst_hit_count",  hit_count,  0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; result_addr = '0; target = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals();
    @(negedge clk) reset_n = 1'b1;
    gap();

    // descending values, seven below target
    for (int j = 0; j < NUM_NONCE; j++) ram[16'h100 + j] = 32'h8000_0000 - j;
    run_scan(16'h100, 32'h7FFF_FFF8, 0, 0);
    chk("t1_nonce", best_nonce, 15);
    chk("t1_hash",  best_hash,  32'h7FFF_FFF1);
    chk("t1_hits",  hit_count,  7);
    chk("t1_found", found,      1);
    gap();

    for (int j = 0; j < NUM_NONCE; j++) ram[16'h200 + j] = 32'h1000_0000;
    ram[16'h205] = 32'h0000_1234;
    run_scan(16'h200, 32'h0000_1000, 0, 0);
    chk("t2_nonce", best_nonce, 5);
    chk("t2_hash",  best_hash,  32'h0000_1234);
    chk("t2_found", found,      0);
    gap();

    ram[3] = 32'h42; ram[9] = 32'h42;
    run_scan(16'h0000, 32'h43, 0, 0);
    chk("t3_nonce", best_nonce, 3);
    chk("t3_hits",  hit_count,  2);
    gap();

    // all-ones region and zero target
    run_scan(16'h300, 32'hFFFF_FFFF, 0, 0);
    chk("ff_nonce", best_nonce, 0);
    chk("ff_hash",  best_hash,  32'hFFFF_FFFF);
    gap();
    for (int j = 0; j < NUM_NONCE; j++) ram[16'h400 + j] = $urandom_range(0, 100);
    run_scan(16'h400, 32'h0, 0, 0);
    chk("tz_found", found, 0);
    gap();

    // reset at E8 aborts with no done pulse
    start = 1'b1; result_addr = 16'h100; target = 32'h7FFF_FFF8;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    @(negedge clk) reset_n = 1'b1;
    gap();
    run_scan(16'h100, 32'h7FFF_FFF8, 0, 0);
    gap();

    // back-to-back scans, second holds start through READ
    run_scan(16'h200, 32'h0000_1000, 0, 0);
    run_scan(16'h100, 32'h7FFF_FFF8, 1, 0);
    gap();

    // address wrap
    for (int j = 0; j < NUM_NONCE; j++) ram[16'(16'hFFF8 + j)] = $urandom;
    run_scan(16'hFFF8, 32'h8000_0000, 0, 1);
    gap();

    for (int r = 0; r < 20; r++) begin
      logic [15:0] b;
      logic [31:0] t;
      b = 16'($urandom);
      for (int j = 0; j < NUM_NONCE; j++)
        ram[16'(b + j)] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      run_scan(b, t, bit'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 0) gap();
    end
    gap();
    gap();

    chk("sb_empty", sb_q.size(), 0);
    chk("mem_we_never_high", we_seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
